// File: rtl/glitc_settings_scheduler.sv
// GLITC external-settings register block with a round-robin scheduler feeding an I2C engine.
// Optional feature: define GLITC_SETTINGS_RETRY_EN to reissue failed commands up to MAX_RETRY times.
module glitc_settings_scheduler #(
   parameter int NUM_DAC     = 8,
   parameter int DAC_BITS    = 12,
   parameter int NUM_ATT     = 6,
   parameter int ATT_BITS    = 6,
   parameter int ADDR_BITS   = 5,
   parameter int TIMEOUT_CYC = 65535,
   parameter int MAX_RETRY   = 3
) (
   input  logic                 user_clk_i,
   input  logic                 user_rst_i,
   input  logic                 user_sel_i,
   input  logic                 user_wr_i,
   input  logic [ADDR_BITS-1:0] user_addr_i,
   input  logic [31:0]          user_dat_i,
   output logic [31:0]          user_dat_o,
   output logic                 cmd_valid_o,
   input  logic                 cmd_ready_i,
   output logic                 cmd_type_o,
   output logic [3:0]           cmd_chan_o,
   output logic [15:0]          cmd_data_o,
   output logic                 cmd_eeprom_o,
   input  logic                 done_i,
   input  logic                 done_err_i,
   output logic                 busy_o
);

   localparam int N      = NUM_DAC + NUM_ATT;
   localparam int SLOT_W = 5;
   localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_BITS-1:0] STATUS_ADDR = ADDR_BITS'((1 << ADDR_BITS) - 2);
   localparam logic [ADDR_BITS-1:0] ERRLOG_ADDR = ADDR_BITS'((1 << ADDR_BITS) - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_ISSUE, ST_WAIT} state_t;

   state_t               state_q, state_d;
   logic [DAC_BITS-1:0]  dac_val [NUM_DAC];
   logic [NUM_DAC-1:0]   dac_eep;
   logic [ATT_BITS-1:0]  att_val [NUM_ATT];
   logic [N-1:0]         pending;
   logic [SLOT_W-1:0]    ptr, cur_slot;
   logic [7:0]           last_slot, err_cnt;
   logic                 err_sticky, pause;
   logic [15:0]          err_log;
   logic [TMR_W-1:0]     timer;
   logic                 cmd_type_q, cmd_eep_q;
   logic [3:0]           cmd_chan_q;
   logic [15:0]          cmd_data_q;

   logic                 wr_en, any_pending, pend_hit;
   logic                 scan_type, scan_eep;
   logic [3:0]           scan_chan;
   logic [15:0]          scan_data;
   logic                 take, accept, done_ok, err_evt, retry_now, log_err;
   logic                 unused_cfg;

   assign wr_en       = user_sel_i & user_wr_i;
   assign any_pending = |pending;

   // Look up the slot under the pointer: its pending bit and the command it would produce.
   always_comb begin
      pend_hit  = 1'b0;
      scan_type = 1'b0;
      scan_chan = '0;
      scan_data = '0;
      scan_eep  = 1'b0;
      for (int i = 0; i < N; i++)
         if (ptr == SLOT_W'(i)) pend_hit = pending[i];
      for (int i = 0; i < NUM_DAC; i++)
         if (ptr == SLOT_W'(i)) begin
            scan_chan = 4'(i);
            scan_data = 16'(dac_val[i]);
            scan_eep  = dac_eep[i];
         end
      for (int i = 0; i < NUM_ATT; i++)
         if (ptr == SLOT_W'(NUM_DAC + i)) begin
            scan_type = 1'b1;
            scan_chan = 4'(i);
            scan_data = 16'(att_val[i]);
         end
   end

   assign take    = (state_q == ST_SCAN) && !pause && pend_hit;
   assign accept  = (state_q == ST_ISSUE) && cmd_ready_i;
   assign done_ok = (state_q == ST_WAIT) && done_i && !done_err_i;
   assign err_evt = (state_q == ST_WAIT) && !done_ok &&
                    ((done_i && done_err_i) || (timer == TMR_W'(TIMEOUT_CYC)));

`ifdef GLITC_SETTINGS_RETRY_EN
   localparam int RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RTY_W-1:0] retry_cnt;

   // Retries reuse the snapshot; the count restarts with each freshly scanned slot.
   always_ff @(posedge user_clk_i or posedge user_rst_i) begin
      if (user_rst_i)     retry_cnt <= '0;
      else if (take)      retry_cnt <= '0;
      else if (retry_now) retry_cnt <= retry_cnt + 1'b1;
   end

   assign retry_now  = err_evt && (retry_cnt < RTY_W'(MAX_RETRY));
   assign unused_cfg = ^user_dat_i;
`else
   assign retry_now  = 1'b0;
   assign unused_cfg = ^{user_dat_i, MAX_RETRY[0]};
`endif
   assign log_err = err_evt && !retry_now;

   // State register.
   always_ff @(posedge user_clk_i or posedge user_rst_i) begin
      if (user_rst_i) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (any_pending && !pause) state_d = ST_SCAN;
         ST_SCAN:  if (pause || !any_pending) state_d = ST_IDLE;
                   else if (pend_hit)         state_d = ST_ISSUE;
         ST_ISSUE: if (cmd_ready_i)           state_d = ST_WAIT;
         ST_WAIT:  if (done_ok || log_err)    state_d = ST_IDLE;
                   else if (retry_now)        state_d = ST_ISSUE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      cmd_valid_o  = (state_q == ST_ISSUE);
      busy_o       = (state_q != ST_IDLE);
      cmd_type_o   = cmd_type_q;
      cmd_chan_o   = cmd_chan_q;
      cmd_data_o   = cmd_data_q;
      cmd_eeprom_o = cmd_eep_q;
   end

   // Setting registers and pending flags; a user write wins over the scheduler's clear.
   always_ff @(posedge user_clk_i or posedge user_rst_i) begin
      if (user_rst_i) begin
         pending <= '0;
         dac_eep <= '0;
         for (int i = 0; i < NUM_DAC; i++) dac_val[i] <= '0;
         for (int i = 0; i < NUM_ATT; i++) att_val[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++)
            if (wr_en && user_addr_i == ADDR_BITS'(i)) pending[i] <= 1'b1;
            else if (take && ptr == SLOT_W'(i))        pending[i] <= 1'b0;
         for (int i = 0; i < NUM_DAC; i++)
            if (wr_en && user_addr_i == ADDR_BITS'(i)) begin
               dac_val[i] <= user_dat_i[DAC_BITS-1:0];
               dac_eep[i] <= user_dat_i[15];
            end
         for (int i = 0; i < NUM_ATT; i++)
            if (wr_en && user_addr_i == ADDR_BITS'(NUM_DAC + i))
               att_val[i] <= user_dat_i[ATT_BITS-1:0];
      end
   end

   // Pointer, command snapshot and WAIT timer.
   always_ff @(posedge user_clk_i or posedge user_rst_i) begin
      if (user_rst_i) begin
         ptr        <= '0;
         cur_slot   <= '0;
         cmd_type_q <= 1'b0;
         cmd_chan_q <= '0;
         cmd_data_q <= '0;
         cmd_eep_q  <= 1'b0;
         timer      <= '0;
      end else begin
         if (state_q == ST_SCAN && !pause)
            ptr <= (ptr == SLOT_W'(N - 1)) ? '0 : ptr + 1'b1;
         if (take) begin
            cur_slot   <= ptr;
            cmd_type_q <= scan_type;
            cmd_chan_q <= scan_chan;
            cmd_data_q <= scan_data;
            cmd_eep_q  <= scan_eep;
         end
         if (accept)                    timer <= '0;
         else if (state_q == ST_WAIT)   timer <= timer + 1'b1;
      end
   end

   // Status and error log; a logged error in the same cycle as a clear still counts.
   always_ff @(posedge user_clk_i or posedge user_rst_i) begin
      if (user_rst_i) begin
         pause      <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         last_slot  <= '0;
         err_log    <= '0;
      end else begin
         if (wr_en && user_addr_i == STATUS_ADDR) begin
            pause <= user_dat_i[30];
            if (user_dat_i[8]) begin
               err_sticky <= 1'b0;
               err_cnt    <= '0;
               err_log    <= '0;
            end
         end
         if (log_err) begin
            last_slot  <= 8'(cur_slot);
            err_sticky <= 1'b1;
            err_log    <= cmd_data_q;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
         end
      end
   end

   // Combinational register read.
   always_comb begin
      user_dat_o = '0;
      for (int i = 0; i < NUM_DAC; i++)
         if (user_addr_i == ADDR_BITS'(i)) begin
            user_dat_o     = 32'(dac_val[i]);
            user_dat_o[15] = dac_eep[i];
         end
      for (int i = 0; i < NUM_ATT; i++)
         if (user_addr_i == ADDR_BITS'(NUM_DAC + i))
            user_dat_o = 32'(att_val[i]);
      if (user_addr_i == STATUS_ADDR)
         user_dat_o = {any_pending, pause, 6'b0, err_cnt, 7'b0, err_sticky, last_slot};
      if (user_addr_i == ERRLOG_ADDR)
         user_dat_o = {16'b0, err_log};
   end

endmodule

// File: tb/tb_glitc_settings_scheduler.sv
// Directed self-checking bench for glitc_settings_scheduler (short timeout for simulation speed).
module tb_glitc_settings_scheduler;

   localparam int TIMEOUT = 40;
   localparam logic [4:0] STATUS = 5'd30;
   localparam logic [4:0] ERRLOG = 5'd31;
`ifdef GLITC_SETTINGS_RETRY_EN
   localparam int ATTEMPTS = 4;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic        user_clk_i = 1'b0;
   logic        user_rst_i = 1'b1;
   logic        user_sel_i = 1'b0;
   logic        user_wr_i = 1'b0;
   logic [4:0]  user_addr_i = '0;
   logic [31:0] user_dat_i = '0;
   logic [31:0] user_dat_o;
   logic        cmd_valid_o;
   logic        cmd_ready_i = 1'b0;
   logic        cmd_type_o;
   logic [3:0]  cmd_chan_o;
   logic [15:0] cmd_data_o;
   logic        cmd_eeprom_o;
   logic        done_i = 1'b0;
   logic        done_err_i = 1'b0;
   logic        busy_o;

   int checks = 0;
   int fails  = 0;

   always #5 user_clk_i = ~user_clk_i;

   glitc_settings_scheduler #(.TIMEOUT_CYC(TIMEOUT)) dut (
      .user_clk_i(user_clk_i), .user_rst_i(user_rst_i), .user_sel_i(user_sel_i),
      .user_wr_i(user_wr_i), .user_addr_i(user_addr_i), .user_dat_i(user_dat_i),
      .user_dat_o(user_dat_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .cmd_type_o(cmd_type_o), .cmd_chan_o(cmd_chan_o), .cmd_data_o(cmd_data_o),
      .cmd_eeprom_o(cmd_eeprom_o), .done_i(done_i), .done_err_i(done_err_i), .busy_o(busy_o)
   );

   task automatic step();
      @(negedge user_clk_i);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
      user_sel_i  = 1'b1;
      user_wr_i   = 1'b1;
      user_addr_i = addr;
      user_dat_i  = data;
      step();
      user_sel_i = 1'b0;
      user_wr_i  = 1'b0;
      user_dat_i = '0;
   endtask

   task automatic checkReg(input string tag, input logic [4:0] addr, input logic [31:0] expected);
      user_addr_i = addr;
      #1;
      checkOutput(tag, user_dat_o, expected);
   endtask

   task automatic expectCmd(input string tag, input logic t, input logic [3:0] c,
                            input logic [15:0] d, input logic e);
      checkOutput(tag, 32'({cmd_valid_o, cmd_type_o, cmd_chan_o, cmd_data_o, cmd_eeprom_o}),
                  32'({1'b1, t, c, d, e}));
   endtask

   task automatic waitValid(input string tag);
      int n = 0;
      while (!cmd_valid_o && n < 16) begin
         step();
         n++;
      end
      checkOutput(tag, 32'(cmd_valid_o), 32'd1);
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n = 0;
      while (busy_o && n < budget) begin
         step();
         n++;
      end
      checkOutput(tag, 32'(busy_o), 32'd0);
   endtask

   task automatic acceptCmd();
      cmd_ready_i = 1'b1;
      step();
      cmd_ready_i = 1'b0;
   endtask

   task automatic finishCmd(input logic err);
      done_i     = 1'b1;
      done_err_i = err;
      step();
      done_i     = 1'b0;
      done_err_i = 1'b0;
   endtask

   task automatic watchNoValid(input string tag, input int cycles);
      logic seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (cmd_valid_o) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      // Reset state
      step(); step();
      checkOutput("rst_valid_busy", 32'({cmd_valid_o, busy_o}), 32'd0);
      checkOutput("rst_cmd_fields", 32'({cmd_type_o, cmd_chan_o, cmd_data_o, cmd_eeprom_o}), 32'd0);
      user_rst_i = 1'b0;
      step();
      checkReg("rst_status", STATUS, 32'h0);
      checkReg("rst_dac2", 5'd2, 32'h0);

      // Single DAC update with EEPROM commit
      applyStimulus(5'd2, 32'h0000_8ABC);
      checkReg("dac2_readback", 5'd2, 32'h0000_8ABC);
      waitValid("dac2_valid");
      expectCmd("dac2_cmd", 1'b0, 4'd2, 16'h0ABC, 1'b1);
      checkReg("dac2_pending_clr", STATUS, 32'h0);
      acceptCmd();
      checkOutput("dac2_wait", 32'({cmd_valid_o, busy_o}), 32'b01);
      finishCmd(1'b0);
      checkOutput("dac2_idle", 32'(busy_o), 32'd0);
      checkReg("dac2_status", STATUS, 32'h0);

      // Ordering from pointer 0: DAC0 before ATT5 (slot 13)
      user_rst_i = 1'b1;
      step();
      user_rst_i = 1'b0;
      applyStimulus(5'd13, 32'h0000_003F);
      applyStimulus(5'd0, 32'h0000_0123);
      waitValid("order_first_valid");
      expectCmd("order_first_dac0", 1'b0, 4'd0, 16'h0123, 1'b0);
      checkReg("order_att5_pending", STATUS, 32'h8000_0000);
      acceptCmd();
      finishCmd(1'b0);
      waitValid("order_second_valid");
      expectCmd("order_second_att5", 1'b1, 4'd5, 16'h003F, 1'b0);
      acceptCmd();
      finishCmd(1'b0);
      checkReg("order_done_status", STATUS, 32'h0);

      // Back-pressure: command stable for 20 cycles, done outside WAIT ignored
      applyStimulus(5'd4, 32'h0000_05A5);
      waitValid("stall_valid");
      for (int i = 0; i < 20; i++) begin
         done_i = (i == 7);
         step();
         expectCmd("stall_stable", 1'b0, 4'd4, 16'h05A5, 1'b0);
      end
      done_i = 1'b0;
      acceptCmd();
      checkOutput("stall_accept_wait", 32'({cmd_valid_o, busy_o}), 32'b01);
      finishCmd(1'b0);
      checkOutput("stall_idle", 32'(busy_o), 32'd0);

      // NACK on DAC3 (with retry build: every attempt fails, only the last is logged)
      applyStimulus(5'd3, 32'h0000_0777);
      for (int i = 0; i < ATTEMPTS; i++) begin
         waitValid("nack_valid");
         expectCmd("nack_cmd", 1'b0, 4'd3, 16'h0777, 1'b0);
         acceptCmd();
         finishCmd(1'b1);
      end
      checkOutput("nack_idle", 32'(busy_o), 32'd0);
      checkReg("nack_status", STATUS, 32'h0001_0103);
      checkReg("nack_errlog", ERRLOG, 32'h0000_0777);

`ifdef GLITC_SETTINGS_RETRY_EN
      // Three errors then success: four issues, nothing logged
      applyStimulus(5'd6, 32'h0000_0666);
      for (int i = 0; i < 4; i++) begin
         waitValid("retry_valid");
         expectCmd("retry_cmd", 1'b0, 4'd6, 16'h0666, 1'b0);
         acceptCmd();
         finishCmd(i < 3);
      end
      checkOutput("retry_idle", 32'(busy_o), 32'd0);
      checkReg("retry_status", STATUS, 32'h0001_0103);
`endif

      // Timeout on ATT0 (slot 8), then clear via STATUS bit 8
      applyStimulus(5'd8, 32'h0000_0015);
      waitValid("tmo_valid");
      acceptCmd();
      for (int i = 0; i < TIMEOUT - 5; i++) step();
      checkOutput("tmo_not_early", 32'(busy_o), 32'd1);
      waitIdle("tmo_idle", ATTEMPTS * (TIMEOUT + 3) + 10);
      checkReg("tmo_status", STATUS, 32'h0002_0108);
      checkReg("tmo_errlog", ERRLOG, 32'h0000_0015);
      applyStimulus(STATUS, 32'h0000_0100);
      checkReg("clr_status", STATUS, 32'h0000_0008);
      checkReg("clr_errlog", ERRLOG, 32'h0);

      // Pause blocks new scans
      applyStimulus(STATUS, 32'h4000_0000);
      checkReg("pause_status", STATUS, 32'h4000_0008);
      applyStimulus(5'd9, 32'h0000_002A);
      watchNoValid("pause_no_valid", 20);
      checkReg("pause_pending", STATUS, 32'hC000_0008);
      applyStimulus(STATUS, 32'h0);
      waitValid("unpause_valid");
      expectCmd("unpause_att1", 1'b1, 4'd1, 16'h002A, 1'b0);
      acceptCmd();
      finishCmd(1'b0);

      // Rewrite of in-flight DAC1 under pause is reissued after unpause
      applyStimulus(5'd1, 32'h0000_0111);
      waitValid("dac1_valid");
      expectCmd("dac1_first", 1'b0, 4'd1, 16'h0111, 1'b0);
      acceptCmd();
      applyStimulus(STATUS, 32'h4000_0000);
      applyStimulus(5'd1, 32'h0000_0222);
      checkOutput("dac1_still_wait", 32'({cmd_valid_o, busy_o}), 32'b01);
      finishCmd(1'b0);
      checkOutput("dac1_idle_paused", 32'(busy_o), 32'd0);
      watchNoValid("dac1_paused_hold", 10);
      checkReg("dac1_pending", STATUS, 32'hC000_0008);
      applyStimulus(STATUS, 32'h0);
      waitValid("dac1_reissue_valid");
      expectCmd("dac1_reissue", 1'b0, 4'd1, 16'h0222, 1'b0);
      acceptCmd();
      finishCmd(1'b0);
      checkReg("dac1_final_status", STATUS, 32'h0000_0008);

      // Reset mid-transaction abandons it; a late done is ignored
      applyStimulus(5'd5, 32'h0000_00FF);
      waitValid("rstmid_valid");
      acceptCmd();
      checkOutput("rstmid_busy", 32'(busy_o), 32'd1);
      user_rst_i = 1'b1;
      #1;
      checkOutput("rstmid_async", 32'({cmd_valid_o, busy_o}), 32'd0);
      step();
      user_rst_i = 1'b0;
      checkReg("rstmid_dac5", 5'd5, 32'h0);
      finishCmd(1'b0);
      checkOutput("rstmid_done_ignored", 32'({cmd_valid_o, busy_o}), 32'd0);
      checkReg("rstmid_status", STATUS, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
